// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - edge-to-edge interval meter for a slow asynchronous square wave
module clock_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] div_est,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
    localparam logic [MC_W-1:0]  LOCK_V    = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  match_cnt;
    logic             have_prev;

    logic             sig_edge;
    logic             timed_out;
    logic [CNT_W-1:0] diff;
    logic             is_match;
    logic [MC_W-1:0]  match_next;

    assign sig_edge  = s2 ^ s3;
    assign timed_out = (cnt >= TIMEOUT_V);
    assign diff      = (cnt >= div_est) ? (cnt - div_est) : (div_est - cnt);
    // The first capture after entering MEASURE has nothing valid to compare against.
    assign is_match  = have_prev && (diff <= TOL_V);
    assign match_next = !is_match              ? MC_W'(1) :
                        (match_cnt >= LOCK_V)  ? LOCK_V   :
                                                 match_cnt + MC_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            match_cnt <= '0;
            have_prev <= 1'b0;
            div_est   <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                have_prev <= 1'b0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        if (sig_edge) begin
                            cnt       <= CNT_W'(1);
                            timeout   <= 1'b0;
                            have_prev <= 1'b0;
                            match_cnt <= '0;
                            state     <= MEASURE;
                        end else if (timed_out) begin
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    MEASURE: begin
                        // An edge on the threshold cycle is a normal capture, not a timeout.
                        if (sig_edge) begin
                            div_est   <= cnt;
                            valid     <= 1'b1;
                            cnt       <= CNT_W'(1);
                            timeout   <= 1'b0;
                            have_prev <= 1'b1;
                            match_cnt <= match_next;
                            locked    <= (match_next >= LOCK_V);
                        end else if (timed_out) begin
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            have_prev <= 1'b0;
                            cnt       <= '0;
                            state     <= WAIT_FIRST;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - self-checking bench for clock_period_meter
module tb_clock_period_meter;

    localparam int CW = 16;
    localparam int TO = 64;
    localparam int LK = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] div_a, div_b;
    logic          valid_a, valid_b, locked_a, locked_b, timeout_a, timeout_b;

    always #5 clk = ~clk;

    clock_period_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO), .LOCK_COUNT(LK), .TOL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .div_est(div_a), .valid(valid_a), .locked(locked_a), .timeout(timeout_a)
    );

    clock_period_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO), .LOCK_COUNT(LK), .TOL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
        .div_est(div_b), .valid(valid_b), .locked(locked_b), .timeout(timeout_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: time-stamped edges, intervals kept as a list.
    longint        n = 0;
    longint        t_ref = 0;
    int            mode = 0;
    bit            hist [3];
    logic [CW-1:0] m_div = '0;
    bit            m_valid = 1'b0;
    bit            m_timeout = 1'b0;
    int            ivs [$];

    // Stimulus generator state.
    int per = 0;
    int tick = 0;
    bit alt = 1'b0;

    typedef struct {
        bit en;
        int per;
        int len;
        int exp_div;
        bit exp_locked;
        bit exp_timeout;
    } vec_t;
    vec_t vecs [8];

    function automatic bit lock_of(int tol);
        int sz = ivs.size();
        if (sz < LK) return 1'b0;
        for (int i = sz - LK + 1; i < sz; i++) begin
            int d = ivs[i] - ivs[i-1];
            if (d < 0) d = -d;
            if (d > tol) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit e;
        n++;
        if (!rst_n) begin
            hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
            mode = 0; m_div = '0; m_valid = 1'b0; m_timeout = 1'b0;
            ivs.delete();
            return;
        end
        e = hist[1] ^ hist[2];
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sig_in;
        m_valid = 1'b0;
        if (!en) begin
            mode = 0; m_timeout = 1'b0; ivs.delete();
            return;
        end
        if (mode == 0) begin
            mode = 1; t_ref = n + 1;
        end else if (e) begin
            if (mode == 2) begin
                m_div = CW'(n - t_ref);
                m_valid = 1'b1;
                ivs.push_back(int'(n - t_ref));
            end else begin
                ivs.delete();
            end
            mode = 2; t_ref = n; m_timeout = 1'b0;
        end else if (n - t_ref >= TO) begin
            m_timeout = 1'b1; ivs.delete(); mode = 1; t_ref = n + 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        bit la, lb;
        la = lock_of(0);
        lb = lock_of(1);
        checks++;
        if (valid_a !== m_valid || div_a !== m_div || locked_a !== la || timeout_a !== m_timeout) begin
            errors++;
            $display("FAIL model_tol0 n=%0d: got v%b d%0d l%b t%b expected v%b d%0d l%b t%b",
                     n, valid_a, div_a, locked_a, timeout_a, m_valid, m_div, la, m_timeout);
        end
        checks++;
        if (valid_b !== m_valid || div_b !== m_div || locked_b !== lb || timeout_b !== m_timeout) begin
            errors++;
            $display("FAIL model_tol1 n=%0d: got v%b d%0d l%b t%b expected v%b d%0d l%b t%b",
                     n, valid_b, div_b, locked_b, timeout_b, m_valid, m_div, lb, m_timeout);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_cycle();
        if (per > 0) begin
            tick++;
            if (tick >= per) begin
                sig_in = ~sig_in;
                tick = 0;
                if (alt) per = (per == 9) ? 10 : 9;
            end
        end
    endtask

    task automatic wait_valid(input string name, input int limit, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!valid_a && cyc < limit);
        check(name, valid_a, 1);
    endtask

    initial begin
        int k, nv;

        vecs[0] = '{1'b1, 5, 60, 5, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8, 80, 8, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 0, 100, 8, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 6, 70, 6, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 6, 10, 6, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1, 30, 1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 3, 40, 3, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 0, 20, 3, 1'b1, 1'b0};

        // Reset held with en high and input toggling.
        rst_n = 1'b0; en = 1'b1; per = 1;
        repeat (3) begin
            step();
            check("reset_state", {10'd0, valid_a, locked_a, timeout_a, valid_b, locked_b, timeout_b, div_a}, 32'd0);
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; per = vecs[i].per; tick = 0;
            repeat (vecs[i].len) step();
            check($sformatf("vec%0d_div", i), div_a, vecs[i].exp_div);
            check($sformatf("vec%0d_locked", i), locked_a, vecs[i].exp_locked);
            check($sformatf("vec%0d_timeout", i), timeout_a, vecs[i].exp_timeout);
            check($sformatf("vec%0d_locked_tol1", i), locked_b, vecs[i].exp_locked);
        end

        // Stall: timeout exactly TO cycles after the last capture.
        en = 1'b1; per = 5; tick = 0;
        repeat (40) step();
        wait_valid("stall_pre_valid", 20, k);
        per = 0;
        k = 0;
        do begin step(); k++; end while (!timeout_a && k < 100);
        check("stall_timeout_cycles", k, TO);
        check("stall_div_held", div_a, 5);
        check("stall_unlocked", locked_a, 0);
        per = 5; tick = 0;
        k = 0;
        do begin step(); k++; end while (timeout_a && k < 20);
        check("resume_timeout_clear", timeout_a, 0);
        check("resume_first_edge_no_valid", valid_a, 0);
        wait_valid("resume_valid", 20, k);
        check("resume_second_edge_gap", k, 5);

        // Enable drop two cycles before the next capture.
        repeat (30) step();
        check("abort_pre_locked", locked_a, 1);
        wait_valid("abort_pre_valid", 20, k);
        step(); step();
        en = 1'b0;
        step();
        check("abort_unlocked", locked_a, 0);
        check("abort_div_held", div_a, 5);
        nv = 0;
        repeat (10) begin step(); if (valid_a) nv++; end
        check("abort_no_valid", nv, 0);
        en = 1'b1;
        wait_valid("reenable_valid", 40, k);
        check("reenable_needs_two_edges", (k >= 6), 1);
        check("reenable_div", div_a, 5);
        check("reenable_not_locked", locked_a, 0);

        // Alternating 9/10 intervals lock only with TOL=1.
        en = 1'b0; step(); en = 1'b1;
        alt = 1'b1; per = 9; tick = 0;
        nv = 0; k = 0;
        do begin step(); k++; if (valid_b) nv++; end while (!locked_b && k < 200);
        check("tol_locked", locked_b, 1);
        check("tol_captures_to_lock", nv, 4);
        check("tol0_stays_unlocked", locked_a, 0);
        alt = 1'b0;

        // Fastest input: a capture every cycle.
        per = 1; tick = 0;
        repeat (10) step();
        nv = 0;
        repeat (8) begin step(); if (valid_a && div_a == 1) nv++; end
        check("fastest_valid_every_cycle", nv, 8);

        // Randomized segments against the model.
        for (int s = 0; s < 30; s++) begin
            per = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
            tick = 0;
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0; step(); rst_n = 1'b1;
            end
            repeat ($urandom_range(5, 150)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
